// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   regval_t        : 32-bit core register/word value
//   mem_req_e       : requester identity (none, fetch, data read, data write)
//   mem_arb_state_e : arbiter transaction state
package mem_port_arbiter_pkg;

   typedef logic [31:0] regval_t;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_FETCH,
      REQ_READ,
      REQ_WRITE
   } mem_req_e;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } mem_arb_state_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant selection for the memory port arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   : round-robin over fetch -> read -> write, starting after last_owner_i
//   undefined : fixed priority write > read > fetch (last_owner_i ignored)
// Ports:
//   fetch_en_i, read_en_i, write_en_i : pending requests
//   last_owner_i                      : owner of the most recent completed transaction
//   winner_o                          : selected requester, REQ_NONE when nothing pending
module mem_arb_picker
   import mem_port_arbiter_pkg::*;
(
   input  logic     fetch_en_i,
   input  logic     read_en_i,
   input  logic     write_en_i,
   input  mem_req_e last_owner_i,
   output mem_req_e winner_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Search order rotates so the requester after the last owner is tried first.
   always_comb begin
      winner_o = REQ_NONE;
      unique case (last_owner_i)
         REQ_FETCH: begin
            if (read_en_i)       winner_o = REQ_READ;
            else if (write_en_i) winner_o = REQ_WRITE;
            else if (fetch_en_i) winner_o = REQ_FETCH;
         end
         REQ_READ: begin
            if (write_en_i)      winner_o = REQ_WRITE;
            else if (fetch_en_i) winner_o = REQ_FETCH;
            else if (read_en_i)  winner_o = REQ_READ;
         end
         default: begin
            if (fetch_en_i)      winner_o = REQ_FETCH;
            else if (read_en_i)  winner_o = REQ_READ;
            else if (write_en_i) winner_o = REQ_WRITE;
         end
      endcase
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = ^last_owner_i;

   always_comb begin
      winner_o = REQ_NONE;
      if (write_en_i)      winner_o = REQ_WRITE;
      else if (read_en_i)  winner_o = REQ_READ;
      else if (fetch_en_i) winner_o = REQ_FETCH;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-bridge master between instruction fetch, data read and
// data write channels. One transaction in flight; results return only to the
// granted requester as a one-cycle valid/done pulse.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (see mem_arb_picker); default is fixed priority write > read > fetch.
// Ports:
//   clock, reset_n                      : clock, async active-low reset
//   i_addr_enable/i_addr -> i_data_valid/i_data : fetch channel
//   r_addr_enable/r_addr -> r_data_valid/r_data : data read channel
//   w_addr_enable/w_addr/w_data -> w_done       : data write channel
//   mem_address, mem_read_n, mem_write_n, mem_write_data : registered bridge outputs
//   mem_read_data, mem_data_ready_n, mem_data_written_n  : bridge responses
//
// state | meaning
// IDLE  | no transaction; arbitrate among enables
// READ  | read strobe low, waiting for mem_data_ready_n
// WRITE | write strobe low, waiting for mem_data_written_n
// DONE  | owner's valid/done pulse is high this cycle
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 25
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  i_addr_enable,
   input  regval_t               i_addr,
   output logic                  i_data_valid,
   output regval_t               i_data,
   input  logic                  r_addr_enable,
   input  regval_t               r_addr,
   output logic                  r_data_valid,
   output regval_t               r_data,
   input  logic                  w_addr_enable,
   input  regval_t               w_addr,
   input  regval_t               w_data,
   output logic                  w_done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read_n,
   output logic                  mem_write_n,
   output regval_t               mem_write_data,
   input  regval_t               mem_read_data,
   input  logic                  mem_data_ready_n,
   input  logic                  mem_data_written_n
);

   mem_arb_state_e          state_q, state_d;
   mem_req_e                owner_q, owner_d;
   mem_req_e                last_owner_q, last_owner_d;
   mem_req_e                winner;
   logic                    armed_q, armed_d;
   logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
   logic                    mem_read_n_q, mem_read_n_d;
   logic                    mem_write_n_q, mem_write_n_d;
   regval_t                 mem_write_data_q, mem_write_data_d;
   regval_t                 i_data_q, i_data_d;
   regval_t                 r_data_q, r_data_d;
   logic                    i_valid_q, i_valid_d;
   logic                    r_valid_q, r_valid_d;
   logic                    w_done_q, w_done_d;

   // Only the low ADDR_WIDTH bits of the core addresses reach the bridge.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr, r_addr, w_addr};

   function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
      return a & ~(ADDR_WIDTH'(3));
   endfunction

   mem_arb_picker u_picker (
      .fetch_en_i   (i_addr_enable),
      .read_en_i    (r_addr_enable),
      .write_en_i   (w_addr_enable),
      .last_owner_i (last_owner_q),
      .winner_o     (winner)
   );

   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      last_owner_d     = last_owner_q;
      armed_d          = armed_q;
      mem_address_d    = mem_address_q;
      mem_read_n_d     = mem_read_n_q;
      mem_write_n_d    = mem_write_n_q;
      mem_write_data_d = mem_write_data_q;
      i_data_d         = i_data_q;
      r_data_d         = r_data_q;
      i_valid_d        = 1'b0;
      r_valid_d        = 1'b0;
      w_done_d         = 1'b0;

      unique case (state_q)
         IDLE: begin
            armed_d = 1'b0;
            owner_d = winner;
            unique case (winner)
               REQ_FETCH: begin
                  mem_address_d = word_addr(i_addr[ADDR_WIDTH-1:0]);
                  mem_read_n_d  = 1'b0;
                  state_d       = READ;
               end
               REQ_READ: begin
                  mem_address_d = word_addr(r_addr[ADDR_WIDTH-1:0]);
                  mem_read_n_d  = 1'b0;
                  state_d       = READ;
               end
               REQ_WRITE: begin
                  mem_address_d    = word_addr(w_addr[ADDR_WIDTH-1:0]);
                  mem_write_data_d = w_data;
                  mem_write_n_d    = 1'b0;
                  state_d          = WRITE;
               end
               default: ;
            endcase
         end
         // Completion is only honoured once the strobe has been low for a full
         // cycle, which guarantees the bridge a minimum two-cycle strobe.
         READ: begin
            armed_d = 1'b1;
            if (armed_q && !mem_data_ready_n) begin
               mem_read_n_d = 1'b1;
               if (owner_q == REQ_FETCH) begin
                  i_data_d  = mem_read_data;
                  i_valid_d = 1'b1;
               end else begin
                  r_data_d  = mem_read_data;
                  r_valid_d = 1'b1;
               end
               state_d = DONE;
            end
         end
         WRITE: begin
            armed_d = 1'b1;
            if (armed_q && !mem_data_written_n) begin
               mem_write_n_d = 1'b1;
               w_done_d      = 1'b1;
               state_d       = DONE;
            end
         end
         DONE: begin
            last_owner_d = owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         owner_q          <= REQ_NONE;
         last_owner_q     <= REQ_WRITE;
         armed_q          <= 1'b0;
         mem_address_q    <= '0;
         mem_read_n_q     <= 1'b1;
         mem_write_n_q    <= 1'b1;
         mem_write_data_q <= '0;
         i_data_q         <= '0;
         r_data_q         <= '0;
         i_valid_q        <= 1'b0;
         r_valid_q        <= 1'b0;
         w_done_q         <= 1'b0;
      end else begin
         state_q          <= state_d;
         owner_q          <= owner_d;
         last_owner_q     <= last_owner_d;
         armed_q          <= armed_d;
         mem_address_q    <= mem_address_d;
         mem_read_n_q     <= mem_read_n_d;
         mem_write_n_q    <= mem_write_n_d;
         mem_write_data_q <= mem_write_data_d;
         i_data_q         <= i_data_d;
         r_data_q         <= r_data_d;
         i_valid_q        <= i_valid_d;
         r_valid_q        <= r_valid_d;
         w_done_q         <= w_done_d;
      end
   end

   assign mem_address    = mem_address_q;
   assign mem_read_n     = mem_read_n_q;
   assign mem_write_n    = mem_write_n_q;
   assign mem_write_data = mem_write_data_q;
   assign i_data         = i_data_q;
   assign r_data         = r_data_q;
   assign i_data_valid   = i_valid_q;
   assign r_data_valid   = r_valid_q;
   assign w_done         = w_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset state, directed corner
// sequences, a table of single-grant vectors and a randomized run checked
// against a transaction-level arbitration model.
module tb_mem_port_arbiter;

   localparam int AW = 25;

   logic          clock;
   logic          reset_n;
   logic          i_addr_enable, r_addr_enable, w_addr_enable;
   logic [31:0]   i_addr, r_addr, w_addr, w_data;
   logic          i_data_valid, r_data_valid, w_done;
   logic [31:0]   i_data, r_data;
   logic [AW-1:0] mem_address;
   logic          mem_read_n, mem_write_n;
   logic [31:0]   mem_write_data, mem_read_data;
   logic          mem_data_ready_n, mem_data_written_n;

   mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .i_addr_enable      (i_addr_enable),
      .i_addr             (i_addr),
      .i_data_valid       (i_data_valid),
      .i_data             (i_data),
      .r_addr_enable      (r_addr_enable),
      .r_addr             (r_addr),
      .r_data_valid       (r_data_valid),
      .r_data             (r_data),
      .w_addr_enable      (w_addr_enable),
      .w_addr             (w_addr),
      .w_data             (w_data),
      .w_done             (w_done),
      .mem_address        (mem_address),
      .mem_read_n         (mem_read_n),
      .mem_write_n        (mem_write_n),
      .mem_write_data     (mem_write_data),
      .mem_read_data      (mem_read_data),
      .mem_data_ready_n   (mem_data_ready_n),
      .mem_data_written_n (mem_data_written_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [31:0] memarr [logic [AW-1:0]];
   int          lat = 2;
   int          low_cnt = 0;
   logic        rdy_n = 1'b1;
   logic        spur_ready = 1'b0;

   assign mem_data_ready_n = rdy_n & ~spur_ready;

   function automatic logic [AW-1:0] word(input logic [31:0] a);
      return a[AW-1:0] & ~25'h3;
   endfunction

   function automatic logic [31:0] memrd(input logic [AW-1:0] a);
      if (memarr.exists(a)) return memarr[a];
      return {7'h0, a} ^ 32'h5A5A_0000;
   endfunction

   // Strobe low for lat cycles (counting the first) before the response appears.
   initial begin
      mem_data_written_n = 1'b1;
      mem_read_data      = 32'h0BAD_0BAD;
   end
   always @(negedge clock) begin
      if (!mem_read_n || !mem_write_n) low_cnt++;
      else low_cnt = 0;
      rdy_n              = !(!mem_read_n && low_cnt >= lat);
      mem_data_written_n = !(!mem_write_n && low_cnt >= lat);
      mem_read_data      = !rdy_n ? memrd(mem_address) : 32'h0BAD_0BAD;
      if (!mem_data_written_n) memarr[mem_address] = mem_write_data;
   end

   // ---------------- reference arbitration (0 fetch, 1 read, 2 write) ----------------
   function automatic int pick(input bit f, input bit r, input bit w, input int last);
      bit [2:0] v;
      v = {w, r, f};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (last + k) % 3;
         if (v[idx]) return idx;
      end
      return -1;
`else
      if (last < -1) return -2;
      if (v[2]) return 2;
      if (v[1]) return 1;
      if (v[0]) return 0;
      return -1;
`endif
   endfunction

   function automatic logic [2:0] pulses();
      return {w_done, r_data_valid, i_data_valid};
   endfunction

   task automatic idle_inputs();
      i_addr_enable = 0; r_addr_enable = 0; w_addr_enable = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      idle_inputs();
      reset_n = 0;
      repeat (2) @(negedge clock);
      reset_n = 1;
      @(negedge clock);
   endtask

   typedef struct {
      bit f, r, w;
      int lat;
      int exp_owner;
   } vec_t;

   initial begin
      vec_t vecs[$];
      logic [2:0] seq[$];
      int   cnt_low, vcnt, bad, rdlow, wcnt, widx, last_low, multi, exp_o;
      logic [31:0] dat, exp_d;
      logic [AW-1:0] got_addr;
      bit seen;

      reset_n = 0;
      idle_inputs();
      i_addr = 0; r_addr = 0; w_addr = 0; w_data = 0;
      repeat (2) @(negedge clock);
      chk("reset_read_n", mem_read_n, 1);
      chk("reset_write_n", mem_write_n, 1);
      chk("reset_addr", mem_address, 0);
      chk("reset_wdata", mem_write_data, 0);
      chk("reset_data", {i_data, r_data}, 0);
      chk("reset_pulses", pulses(), 0);
      reset_n = 1;
      @(negedge clock);

      // 1. reset in the middle of a read
      lat = 10;
      i_addr = 32'h0000_0800; i_addr_enable = 1;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clock);
         seen = !mem_read_n;
      end
      chk("rst_mid_strobe_seen", seen, 1);
      @(negedge clock);
      #2 reset_n = 0;
      #1 chk("rst_mid_async_release", mem_read_n, 1);
      i_addr_enable = 0;
      @(negedge clock);
      reset_n = 1;
      vcnt = 0; rdlow = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (i_data_valid) vcnt++;
         if (!mem_read_n || !mem_write_n) rdlow++;
      end
      chk("rst_mid_no_pulse", vcnt, 0);
      chk("rst_mid_idle", rdlow, 0);

      // 2. fetch of 0x1237 with a three-cycle strobe
      lat = 3;
      memarr[25'h1234] = 32'hDEAD_BEEF;
      i_addr = 32'h0000_1237; i_addr_enable = 1;
      cnt_low = 0; vcnt = 0; dat = 0; got_addr = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clock);
         if (!mem_read_n) begin
            if (cnt_low == 0) got_addr = mem_address;
            cnt_low++;
         end
         if (i_data_valid) begin
            vcnt++; dat = i_data; i_addr_enable = 0;
         end
      end
      chk("fetch_addr", got_addr, 25'h1234);
      chk("fetch_strobe_len", cnt_low, 3);
      chk("fetch_valid_len", vcnt, 1);
      chk("fetch_data", dat, 32'hDEAD_BEEF);

`ifndef MEM_ARB_ROUND_ROBIN_EN
      // table of single-grant vectors (fixed priority)
      vecs.push_back('{1, 0, 0, 2, 0});
      vecs.push_back('{0, 1, 0, 2, 1});
      vecs.push_back('{0, 0, 1, 4, 2});
      vecs.push_back('{1, 1, 0, 2, 1});
      vecs.push_back('{1, 0, 1, 3, 2});
      vecs.push_back('{0, 1, 1, 2, 2});
      vecs.push_back('{1, 1, 1, 5, 2});
      foreach (vecs[v]) begin
         lat = vecs[v].lat;
         i_addr = 32'h0000_1000 + v * 16 + 1;
         r_addr = 32'h0000_2000 + v * 16 + 2;
         w_addr = 32'h0000_3000 + v * 16 + 3;
         w_data = $urandom;
         exp_d = (vecs[v].exp_owner == 0) ? memrd(word(i_addr)) :
                 (vecs[v].exp_owner == 1) ? memrd(word(r_addr)) : w_data;
         i_addr_enable = vecs[v].f; r_addr_enable = vecs[v].r; w_addr_enable = vecs[v].w;
         seen = 0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            seen = !mem_read_n || !mem_write_n;
         end
         chk($sformatf("vec%0d_strobe_seen", v), seen, 1);
         chk($sformatf("vec%0d_kind", v), !mem_write_n, vecs[v].exp_owner == 2);
         chk($sformatf("vec%0d_addr", v), mem_address,
             (vecs[v].exp_owner == 0) ? word(i_addr) :
             (vecs[v].exp_owner == 1) ? word(r_addr) : word(w_addr));
         seen = 0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = pulses() != 0;
         end
         chk($sformatf("vec%0d_pulse", v), pulses(), 3'b1 << vecs[v].exp_owner);
         chk($sformatf("vec%0d_data", v),
             (vecs[v].exp_owner == 0) ? i_data :
             (vecs[v].exp_owner == 1) ? r_data : memarr[word(w_addr)], exp_d);
         idle_inputs();
         repeat (2) @(negedge clock);
      end

      // 3. all three at once: write, read, fetch, one pulse per cycle
      lat = 2;
      i_addr = 32'h100; r_addr = 32'h200; w_addr = 32'h300; w_data = 32'h1111_2222;
      i_addr_enable = 1; r_addr_enable = 1; w_addr_enable = 1;
      multi = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if ($countones(pulses()) > 1) multi++;
         if (pulses() != 0) begin
            seq.push_back(pulses());
            if (w_done) w_addr_enable = 0;
            if (r_data_valid) r_addr_enable = 0;
            if (i_data_valid) i_addr_enable = 0;
         end
      end
      chk("all3_count", seq.size(), 3);
      if (seq.size() == 3) begin
         chk("all3_first_write", seq[0], 3'b100);
         chk("all3_second_read", seq[1], 3'b010);
         chk("all3_third_fetch", seq[2], 3'b001);
      end
      chk("all3_single_pulse", multi, 0);
      idle_inputs();
`endif

      // 4. write 0xA5 to 0x40
      lat = 3;
      w_addr = 32'h40; w_data = 32'hA5; w_addr_enable = 1;
      cnt_low = 0; bad = 0; rdlow = 0; wcnt = 0; widx = -10; last_low = -20;
      for (int k = 0; k < 15; k++) begin
         @(negedge clock);
         if (!mem_write_n) begin
            cnt_low++; last_low = k;
            if (mem_write_data !== 32'hA5 || mem_address !== 25'h40) bad++;
         end
         if (!mem_read_n) rdlow++;
         if (w_done) begin
            wcnt++; widx = k; w_addr_enable = 0;
         end
      end
      chk("wr_strobe_len", cnt_low, 3);
      chk("wr_data_stable", bad, 0);
      chk("wr_no_read_strobe", rdlow, 0);
      chk("wr_done_len", wcnt, 1);
      chk("wr_done_timing", widx, last_low + 1);
      chk("wr_mem_content", memarr[25'h40], 32'hA5);

      // 6. spurious ready in IDLE
      lat = 2;
      @(negedge clock);
      spur_ready = 1;
      @(negedge clock);
      spur_ready = 0;
      vcnt = 0; rdlow = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (pulses() != 0) vcnt++;
         if (!mem_read_n || !mem_write_n) rdlow++;
      end
      chk("spur_no_pulse", vcnt, 0);
      chk("spur_no_strobe", rdlow, 0);
      r_addr = 32'h0000_0500; r_addr_enable = 1; seen = 0; cnt_low = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clock);
         if (!mem_read_n) cnt_low++;
         seen = r_data_valid;
      end
      chk("spur_then_read_valid", seen, 1);
      chk("spur_then_read_len", cnt_low, 2);
      chk("spur_then_read_data", r_data, memrd(25'h500));
      r_addr_enable = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
      // 5. fetch and read held continuously alternate
      do_reset();
      i_addr = 32'h0000_0700; r_addr = 32'h0000_0900;
      i_addr_enable = 1; r_addr_enable = 1;
      seq.delete();
      seen = 0;
      for (int k = 0; k < 60 && seq.size() < 4; k++) begin
         @(negedge clock);
         if (!mem_read_n && !seen) seq.push_back(mem_address == 25'h700 ? 3'b001 : 3'b010);
         seen = !mem_read_n;
      end
      chk("rr_grant_count", seq.size(), 4);
      if (seq.size() == 4) begin
         chk("rr_first_fetch", seq[0], 3'b001);
         chk("rr_second_read", seq[1], 3'b010);
         chk("rr_third_fetch", seq[2], 3'b001);
         chk("rr_fourth_read", seq[3], 3'b010);
      end
      idle_inputs();
`endif

      // randomized run against the transaction-level model
      do_reset();
      begin
         int inflight, last_model;
         bit prev_strobe, strobe;
         logic [31:0] exp_rd;
         inflight = -1; last_model = 2; prev_strobe = 0; exp_rd = 0;
         for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clock);
            if ($countones(pulses()) > 1) chk("rnd_one_pulse", $countones(pulses()), 1);
            strobe = !mem_read_n || !mem_write_n;
            if (strobe && !prev_strobe) begin
               exp_o = pick(i_addr_enable, r_addr_enable, w_addr_enable, last_model);
               chk("rnd_grant_exists", exp_o >= 0, 1);
               chk("rnd_idle_before_grant", inflight, -1);
               chk("rnd_kind", !mem_write_n, exp_o == 2);
               chk("rnd_addr", mem_address,
                   (exp_o == 0) ? word(i_addr) : (exp_o == 1) ? word(r_addr) : word(w_addr));
               if (exp_o == 2) chk("rnd_wdata", mem_write_data, w_data);
               else exp_rd = memrd(mem_address);
               inflight = exp_o;
            end
            if (pulses() != 0) begin
               chk("rnd_pulse", pulses(), (inflight >= 0) ? (3'b1 << inflight) : 3'b0);
               if (inflight == 0) chk("rnd_idata", i_data, exp_rd);
               if (inflight == 1) chk("rnd_rdata", r_data, exp_rd);
               if (inflight == 0) i_addr_enable = 0;
               if (inflight == 1) r_addr_enable = 0;
               if (inflight == 2) w_addr_enable = 0;
               if (inflight >= 0) last_model = inflight;
               inflight = -1;
            end
            prev_strobe = strobe;
            if (cyc < 560) begin
               lat = $urandom_range(4, 1);
               if (!i_addr_enable && $urandom_range(3) == 0) begin
                  i_addr = $urandom; i_addr_enable = 1;
               end
               if (!r_addr_enable && $urandom_range(3) == 0) begin
                  r_addr = $urandom; r_addr_enable = 1;
               end
               if (!w_addr_enable && $urandom_range(3) == 0) begin
                  w_addr = $urandom; w_data = $urandom; w_addr_enable = 1;
               end
            end
         end
         chk("rnd_drained", {i_addr_enable, r_addr_enable, w_addr_enable}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
